rect_detect: RTL and testbench

- Pixel-stream sink that consumes the SDL-style video output of our display tops (sx, sy, de, 8-bit RGB) and recovers the bounding box of all pixels matching a key colour, once per frame.
- Used in simulation and hardware self-test to check that drawing logic placed a rectangle at the intended screen coordinates.
- Reports per-frame results with a one-cycle valid pulse and flags stream synchronisation faults.

---
 rtl/rect_detect.sv | 163 ++++++++++++++++
 tb/tb_rect_detect.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_detect.sv
// rect_detect: pixel-stream sink that recovers, once per frame, the bounding
// box of every pixel that matches a key colour. It reports the result with a
// one-cycle frame_valid pulse and flags a restarted frame with sync_err.
// Optional build macro: RECT_DETECT_STATS_EN adds a saturating match counter
// on match_cnt. Without it, match_cnt is tied to 0.
module rect_detect #(
  parameter int          CORDW = 10,
  parameter int          H_RES = 640,
  parameter int          V_RES = 480,
  parameter logic [7:0]  KEY_R = 8'hFF,
  parameter logic [7:0]  KEY_G = 8'hFF,
  parameter logic [7:0]  KEY_B = 8'hFF,
  parameter int          CNTW  = 19
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  output logic [CORDW-1:0] box_x0,
  output logic [CORDW-1:0] box_y0,
  output logic [CORDW-1:0] box_x1,
  output logic [CORDW-1:0] box_y1,
  output logic             found,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [CNTW-1:0]  match_cnt
);

  localparam logic [CORDW-1:0] LAST_X = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] LAST_Y = CORDW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t           state;
  logic             hit;
  logic [CORDW-1:0] min_x, min_y, max_x, max_y;

  logic             start, last, match, accept;
  logic             b_hit, nx_hit;
  logic [CORDW-1:0] b_min_x, b_min_y, b_max_x, b_max_y;
  logic [CORDW-1:0] nx_min_x, nx_min_y, nx_max_x, nx_max_y;

  // Decode the pixel and compute the accumulator values after absorbing it.
  // A start pixel always opens a fresh frame, so it sees cleared accumulators.
  always_comb begin
    start  = de && (sx == '0) && (sy == '0);
    last   = de && (sx == LAST_X) && (sy == LAST_Y);
    match  = de && (r == KEY_R) && (g == KEY_G) && (b == KEY_B);
    accept = (state == SCAN && de) || (state == IDLE && start);

    b_hit   = start ? 1'b0 : hit;
    b_min_x = start ? '0 : min_x;
    b_min_y = start ? '0 : min_y;
    b_max_x = start ? '0 : max_x;
    b_max_y = start ? '0 : max_y;

    nx_hit   = b_hit || match;
    nx_min_x = b_min_x;
    nx_min_y = b_min_y;
    nx_max_x = b_max_x;
    nx_max_y = b_max_y;
    if (match) begin
      if (!b_hit) begin
        nx_min_x = sx;
        nx_min_y = sy;
        nx_max_x = sx;
        nx_max_y = sy;
      end else begin
        if (sx < b_min_x) nx_min_x = sx;
        if (sy < b_min_y) nx_min_y = sy;
        if (sx > b_max_x) nx_max_x = sx;
        if (sy > b_max_y) nx_max_y = sy;
      end
    end
  end

  // Frame FSM, accumulators and registered report outputs. The report is
  // loaded on the edge that samples the last pixel, so it becomes visible
  // during the one-cycle REPORT state.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state       <= IDLE;
      hit         <= 1'b0;
      min_x       <= '0;
      min_y       <= '0;
      max_x       <= '0;
      max_y       <= '0;
      box_x0      <= '0;
      box_y0      <= '0;
      box_x1      <= '0;
      box_y1      <= '0;
      found       <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      case (state)
        IDLE, SCAN: begin
          if (accept) begin
            hit   <= nx_hit;
            min_x <= nx_min_x;
            min_y <= nx_min_y;
            max_x <= nx_max_x;
            max_y <= nx_max_y;
            state <= SCAN;
            if (state == SCAN && start) sync_err <= 1'b1;
            if (last) begin
              box_x0      <= nx_hit ? nx_min_x : '0;
              box_y0      <= nx_hit ? nx_min_y : '0;
              box_x1      <= nx_hit ? nx_max_x : '0;
              box_y1      <= nx_hit ? nx_max_y : '0;
              found       <= nx_hit;
              frame_valid <= 1'b1;
              state       <= REPORT;
            end
          end
        end
        REPORT: begin
          // Any pixel here is ignored; legal streams are blanking now.
          hit   <= 1'b0;
          min_x <= '0;
          min_y <= '0;
          max_x <= '0;
          max_y <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECT_DETECT_STATS_EN
  logic [CNTW-1:0] cnt, b_cnt, nx_cnt;

  // Saturating count of matches within the current frame.
  always_comb begin
    b_cnt  = start ? '0 : cnt;
    nx_cnt = b_cnt;
    if (match && (b_cnt != '1)) nx_cnt = b_cnt + CNTW'(1);
  end

  // Counter follows the same accept/report/clear timing as the box.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      cnt       <= '0;
      match_cnt <= '0;
    end else if (state == REPORT) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= nx_cnt;
      if (last) match_cnt <= nx_cnt;
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_rect_detect.sv
// Self-checking bench for rect_detect on a reduced 20x12 raster with
// blanking. Frames are described as a key-pixel map; the expected box is
// computed directly from that map.
module tb_rect_detect;

  localparam int CORDW = 10;
  localparam int H     = 20;
  localparam int V     = 12;
  localparam int HT    = H + 4;
  localparam int VT    = V + 2;
  localparam int CNTW  = 9;
  localparam logic [23:0] KEY = 24'hFFFFFF;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n = 1'b0;
  logic [CORDW-1:0] sx = '0, sy = '0;
  logic             de = 1'b0;
  logic [7:0]       r = '0, g = '0, b = '0;
  logic [CORDW-1:0] box_x0, box_y0, box_x1, box_y1;
  logic             found, frame_valid, sync_err;
  logic [CNTW-1:0]  match_cnt;

  rect_detect #(.CORDW(CORDW), .H_RES(H), .V_RES(V), .KEY_R(KEY[23:16]),
                .KEY_G(KEY[15:8]), .KEY_B(KEY[7:0]), .CNTW(CNTW)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .r(r), .g(g), .b(b), .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1),
    .box_y1(box_y1), .found(found), .frame_valid(frame_valid),
    .sync_err(sync_err), .match_cnt(match_cnt));

  always #5 clk_pix = ~clk_pix;

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk_pix) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (sync_err === 1'b1) se_cnt++;
  end

  logic [H-1:0] kmap [V];

  typedef struct { bit f; int x0; int y0; int x1; int y1; int n; } res_t;

  function automatic res_t add_px(input res_t e, input int x, input int y);
    if (!e.f) begin
      e.f = 1; e.x0 = x; e.x1 = x; e.y0 = y; e.y1 = y;
    end else begin
      if (x < e.x0) e.x0 = x;
      if (x > e.x1) e.x1 = x;
      if (y < e.y0) e.y0 = y;
      if (y > e.y1) e.y1 = y;
    end
    e.n++;
    return e;
  endfunction

  function automatic res_t model(input int ex_x, input int ex_y);
    res_t e = '{0, 0, 0, 0, 0, 0};
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (kmap[y][x]) e = add_px(e, x, y);
    if (ex_x >= 0) e = add_px(e, ex_x, ex_y);
    return e;
  endfunction

  function automatic logic [4*CORDW:0] exp_vec(input res_t e);
    return {e.f, CORDW'(e.x0), CORDW'(e.y0), CORDW'(e.x1), CORDW'(e.y1)};
  endfunction

  function automatic logic [CNTW-1:0] exp_cnt(input res_t e);
`ifdef RECT_DETECT_STATS_EN
    return CNTW'(e.n);
`else
    return CNTW'(e.n * 0);
`endif
  endfunction

  task automatic clear_map();
    for (int y = 0; y < V; y++) kmap[y] = '0;
  endtask

  task automatic random_map(input int density);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        kmap[y][x] = ($urandom_range(0, 99) < density);
  endtask

  // Drive one pixel for one clock; non-key pixels get a random colour that is
  // sometimes a single-bit near miss of the key.
  task automatic drive_px(input int x, input int y, input bit d, input bit k, input bit rst);
    logic [23:0] c;
    c = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      c = KEY;
      c[$urandom_range(0, 23)] ^= 1'b1;
    end
    if (c == KEY) c ^= 24'h1;
    if (k) c = KEY;
    rst_pix_n = rst;
    sx = CORDW'(x); sy = CORDW'(y); de = d;
    {r, g, b} = c;
    @(posedge clk_pix);
    #1;
  endtask

  // Snapshot of DUT outputs in the cycle after the last pixel was sampled.
  logic             fv_last, lfound, se_start;
  logic [CORDW-1:0] lx0, ly0, lx1, ly1;
  logic [CNTW-1:0]  lcnt;

  // Stream lines y_from..y_to-1 with horizontal blanking; vertical blanking
  // follows when the frame end is reached. An optional extra de=1 key pixel
  // at (ex_x, ex_y) is placed in the hblank of line ex_line.
  task automatic send_lines(input int y_from, input int y_to,
                            input int ex_x, input int ex_y, input int ex_line);
    fv_last = 1'b0;
    for (int y = y_from; y < y_to; y++)
      for (int x = 0; x < HT; x++) begin
        if (x < H) begin
          drive_px(x, y, 1'b1, kmap[y][x], 1'b1);
          if (x == 0 && y == 0) se_start = sync_err;
          if (x == H - 1 && y == V - 1) begin
            fv_last = frame_valid; lfound = found; lcnt = match_cnt;
            lx0 = box_x0; ly0 = box_y0; lx1 = box_x1; ly1 = box_y1;
          end
        end else if (y == ex_line && x == H + 1) begin
          drive_px(ex_x, ex_y, 1'b1, 1'b1, 1'b1);
        end else begin
          drive_px(x, y, 1'b0, 1'b0, 1'b1);
        end
      end
    if (y_to == V)
      for (int y = V; y < VT; y++)
        for (int x = 0; x < HT; x++) drive_px(x, y, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_px(0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({found, box_x0, box_y0, box_x1, box_y1} !== '0) begin
      bad++; $display("FAIL reset_box got=%h want=0", {found, box_x0, box_y0, box_x1, box_y1});
    end
    total++;
    if ({frame_valid, sync_err, match_cnt} !== '0) begin
      bad++; $display("FAIL reset_pulses got=%h want=0", {frame_valid, sync_err, match_cnt});
    end
  endtask

  task automatic test_rect();
    int base = fv_cnt;
    int sbase = se_cnt;
    res_t e;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) kmap[y][x] = (x > 4 && x < 15 && y > 2 && y < 10);
    e = model(-1, -1);
    send_lines(0, V, -1, -1, -1);
    total++;
    if (fv_last !== 1'b1) begin bad++; $display("FAIL rect_latency got=%b want=1", fv_last); end
    total++;
    if ({lfound, lx0, ly0, lx1, ly1} !== {1'b1, 10'd5, 10'd3, 10'd14, 10'd9}) begin
      bad++; $display("FAIL rect_box got=%h want=%h", {lfound, lx0, ly0, lx1, ly1}, {1'b1, 10'd5, 10'd3, 10'd14, 10'd9});
    end
    total++;
    if (lcnt !== exp_cnt(e)) begin bad++; $display("FAIL rect_cnt got=%0d want=%0d", lcnt, exp_cnt(e)); end
    total++;
    if (fv_cnt - base != 1 || se_cnt != sbase || se_start !== 1'b0) begin
      bad++; $display("FAIL rect_pulses got=%0d/%0d want=1/0", fv_cnt - base, se_cnt - sbase);
    end
    total++;
    if (box_x0 !== 10'd5 || frame_valid !== 1'b0) begin
      bad++; $display("FAIL rect_hold got=%0d/%b want=5/0", box_x0, frame_valid);
    end
  endtask

  // Shared shape of a single clean frame checked against the model.
  task automatic test_frame(input string name, input int ex_x, input int ex_y, input int ex_line);
    int base = fv_cnt;
    res_t e = model(ex_x, ex_y);
    send_lines(0, V, ex_x, ex_y, ex_line);
    total++;
    if (fv_last !== 1'b1 || fv_cnt - base != 1) begin
      bad++; $display("FAIL %s_valid got=%b/%0d want=1/1", name, fv_last, fv_cnt - base);
    end
    total++;
    if ({lfound, lx0, ly0, lx1, ly1} !== exp_vec(e)) begin
      bad++; $display("FAIL %s_box got=%h want=%h", name, {lfound, lx0, ly0, lx1, ly1}, exp_vec(e));
    end
    total++;
    if (lcnt !== exp_cnt(e)) begin bad++; $display("FAIL %s_cnt got=%0d want=%0d", name, lcnt, exp_cnt(e)); end
  endtask

  task automatic test_boundaries();
    clear_map();
    test_frame("empty", -1, -1, -1);
    kmap[V-1][H-1] = 1'b1;
    test_frame("lastpx", -1, -1, -1);
    random_map(100);
    test_frame("allmatch", -1, -1, -1);
    // Out-of-range pixels are ordinary pixels and never end the frame.
    random_map(10);
    test_frame("over_y", H - 1, V, 5);
    random_map(10);
    test_frame("over_x", H + 3, 2, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      random_map($urandom_range(0, 3) == 0 ? 1 : $urandom_range(2, 60));
      test_frame("random", -1, -1, -1);
    end
  endtask

  task automatic test_sync_err();
    int base = fv_cnt;
    int sbase = se_cnt;
    clear_map();
    kmap[1][0] = 1'b1;
    kmap[2][3] = 1'b1;
    send_lines(0, 6, -1, -1, -1);
    clear_map();
    kmap[8][7] = 1'b1;
    send_lines(0, V, -1, -1, -1);
    total++;
    if (se_start !== 1'b1 || se_cnt - sbase != 1) begin
      bad++; $display("FAIL sync_pulse got=%b/%0d want=1/1", se_start, se_cnt - sbase);
    end
    total++;
    if (fv_cnt - base != 1 || {lfound, lx0, ly0, lx1, ly1} !== {1'b1, 10'd7, 10'd8, 10'd7, 10'd8}) begin
      bad++; $display("FAIL sync_next got=%0d/%h want=1/%h", fv_cnt - base, {lfound, lx0, ly0, lx1, ly1}, {1'b1, 10'd7, 10'd8, 10'd7, 10'd8});
    end
  endtask

  task automatic test_reset_mid();
    int base;
    random_map(30);
    send_lines(0, 3, -1, -1, -1);
    drive_px(0, 3, 1'b1, 1'b1, 1'b0);
    total++;
    if ({found, box_x0, box_y0, box_x1, box_y1, frame_valid, sync_err, match_cnt} !== '0) begin
      bad++; $display("FAIL rstmid_zero got=%h want=0", {found, box_x0, box_y0, box_x1, box_y1, frame_valid, sync_err, match_cnt});
    end
    base = fv_cnt;
    send_lines(4, V, -1, -1, -1);
    total++;
    if (fv_last !== 1'b0 || fv_cnt != base) begin
      bad++; $display("FAIL rstmid_partial got=%b/%0d want=0/0", fv_last, fv_cnt - base);
    end
    test_frame("rstmid_full", -1, -1, -1);
  endtask

  task automatic test_midstart();
    int base;
    drive_px(0, 0, 1'b0, 1'b0, 1'b0);
    drive_px(0, 0, 1'b0, 1'b0, 1'b0);
    base = fv_cnt;
    random_map(20);
    send_lines(6, V, -1, -1, -1);
    total++;
    if (fv_last !== 1'b0 || fv_cnt != base) begin
      bad++; $display("FAIL midstart_partial got=%b/%0d want=0/0", fv_last, fv_cnt - base);
    end
    test_frame("midstart_full", -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_rect();
    test_boundaries();
    test_back_to_back();
    test_sync_err();
    test_reset_mid();
    test_midstart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
